// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider (div_seq).
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Two's-complement negation, used for magnitudes and sign fix-up.
    function automatic logic [31:0] div_negate(input logic [31:0] x);
        return (~x) + 32'd1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift, trial subtract, keep or restore.
module div_step
    import div_pkg::*;
(
    input  logic [32:0] rem_i,
    input  logic [31:0] dvd_i,
    input  logic [31:0] dvs_i,
    output logic [32:0] rem_o,
    output logic [31:0] dvd_o,
    output logic        qbit_o
);

    logic [32:0] shifted_s;
    logic [32:0] trial_s;
    logic        unused_rem_msb_s;

    // The partial remainder stays below the divisor, so its top bit is always zero.
    assign unused_rem_msb_s = rem_i[32];

    assign shifted_s = {rem_i[31:0], dvd_i[31]};
    assign trial_s   = shifted_s - {1'b0, dvs_i};
    assign qbit_o    = ~trial_s[32];
    assign rem_o     = qbit_o ? trial_s : shifted_s;
    assign dvd_o     = {dvd_i[30:0], qbit_o};

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit divider, one restoring step per cycle, 34-cycle fixed latency.
// Signed (DIV) support is built only when DIV_SIGNED_EN is defined; otherwise all ops are unsigned.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] aorig_q, aorig_d;
    logic        dz_q, dz_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rmd_q, rmd_d;
    logic        dzo_q, dzo_d;
    logic        done_q, done_d;

    logic [32:0] step_rem_s;
    logic [31:0] step_dvd_s;
    logic        unused_qbit_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [31:0] q_fix_s, r_fix_s;
    logic        accept_s;

    assign accept_s = (state_q == IDLE) && start;

    div_step u_step (
        .rem_i  (rem_q),
        .dvd_i  (dvd_q),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem_s),
        .dvd_o  (step_dvd_s),
        .qbit_o (unused_qbit_s)
    );

`ifdef DIV_SIGNED_EN
    logic q_neg_q, q_neg_d;
    logic r_neg_q, r_neg_d;

    assign a_mag_s = (sign && a[31]) ? div_negate(a) : a;
    assign b_mag_s = (sign && b[31]) ? div_negate(b) : b;
    assign q_fix_s = q_neg_q ? div_negate(dvd_q) : dvd_q;
    assign r_fix_s = r_neg_q ? div_negate(rem_q[31:0]) : rem_q[31:0];

    // Result sign flags captured at accept.
    always_comb begin
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        if (accept_s) begin
            q_neg_d = sign & (a[31] ^ b[31]);
            r_neg_d = sign & a[31];
        end else begin
            q_neg_d = q_neg_q;
            r_neg_d = r_neg_q;
        end
    end

    // Sign flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end
`else
    logic unused_sign_s;

    assign unused_sign_s = sign;
    assign a_mag_s       = a;
    assign b_mag_s       = b;
    assign q_fix_s       = dvd_q;
    assign r_fix_s       = rem_q[31:0];
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        aorig_d = aorig_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        dzo_d   = dzo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = 5'(DIV_STEPS - 1);
                    rem_d   = 33'd0;
                    dvd_d   = a_mag_s;
                    dvs_d   = b_mag_s;
                    aorig_d = a;
                    dz_d    = (b == 32'd0);
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d = step_rem_s;
                dvd_d = step_dvd_s;
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dzo_d   = dz_q;
                // Divide by zero reports all-ones and hands back the untouched dividend.
                if (dz_q) begin
                    quot_d = DIV_ZERO_QUOT;
                    rmd_d  = aorig_q;
                end else begin
                    quot_d = q_fix_s;
                    rmd_d  = r_fix_s;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 33'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            aorig_q <= 32'd0;
            dz_q    <= 1'b0;
            quot_q  <= 32'd0;
            rmd_q   <= 32'd0;
            dzo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            aorig_q <= aorig_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            dzo_q   <= dzo_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dzo_q;

endmodule

// File: doc/div_seq.md
# div_seq

Sequential 32-bit integer divider for the ALU datapath, the multi-cycle counterpart of the single-cycle compare logic: it runs the subtract-and-test-sign operation repeatedly, one restoring step per cycle. The core issues a start pulse with dividend and divisor and waits on `busy`. It then takes quotient and remainder on a one-cycle `done` pulse. It sits beside the ALU and serves the DIV and DIVU instructions.

## Interface
- `WIDTH`, 32, operand and result width. Only 32 is supported.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a division. Sampled only when `busy`=0.
- `sign` input 1: 1 selects signed (DIV), 0 selects unsigned (DIVU). Sampled with `start`.
- `a` input 32: dividend. Sampled with `start`.
- `b` input 32: divisor. Sampled with `start`.
- `busy` output 1: a division is in progress.
- `done` output 1: one-cycle pulse that marks results valid.
- `quotient` output 32: result quotient.
- `remainder` output 32: result remainder.
- `div_by_zero` output 1: the last operation had `b`=0. Valid with `done`.

## Operation
- States and transitions:
  - IDLE → CALC when `start`=1.
  - CALC holds for 32 cycles, with a 5-bit counter running 31 down to 0.
  - CALC → FIX when the counter reaches 0.
  - FIX → IDLE after one cycle.
- On accept, register the following:
  - Operand magnitudes: |a| and |b| when `sign`=1, raw values otherwise.
  - `q_neg` = a[31]^b[31] and `r_neg` = a[31], both only when `sign`=1.
  - `div_by_zero` = (b==0).
  - Clear the 33-bit partial remainder.
- Each CALC cycle performs one restoring step:
  - Shift {rem, dvd} left by 1.
  - Trial = rem − divisor, 33-bit.
  - If the trial sign bit is 0, rem = trial and the quotient LSB = 1; otherwise keep rem and set the quotient LSB = 0.
- FIX applies the sign correction:
  - quotient = q_neg ? −q : q.
  - remainder = r_neg ? −r : r.
  - Both are written to the output registers and `done` is asserted.
- Divide by zero: quotient is forced to 32'hFFFFFFFF, remainder is forced to the original `a`, and `div_by_zero`=1, in both signed and unsigned modes.
- Signed overflow (0x80000000 / 0xFFFFFFFF) produces quotient 0x80000000 and remainder 0, with no flag. This falls out of the 32-bit magnitude arithmetic.
- `start` while `busy`=1 is ignored: no queueing and no restart.
- Outputs hold their last values until the next FIX.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter 0.
- Accept and latency:
  - `start` is sampled high at edge N; `busy` is 1 after edge N.
  - CALC covers edges N+1 through N+32; FIX is at edge N+33.
  - After edge N+33, `done`=1 for one cycle, `busy`=0, and the results are valid.
- Fixed latency is 34 cycles from accept to `done`, including divide by zero.
- Back-to-back: `start` may be high during the `done` cycle. It is accepted, and `busy` is 1 again on the next cycle.
- Reset asserted mid-operation aborts immediately to the reset values. No `done` is produced.

## Configuration
- `DIV_SIGNED_EN`:
  - Defined: the `sign` input is honoured, with the magnitude conversion and FIX negation built in.
  - Undefined: the `sign` input is ignored, all operations are unsigned, no negation logic is built, and FIX only registers the outputs. Latency is unchanged.

## Structure
- Shared package `div_pkg` holds:
  - The state enum (IDLE, CALC, FIX).
  - `DIV_WIDTH`=32.
  - `DIV_STEPS`=32.
  - `DIV_ZERO_QUOT`=32'hFFFFFFFF.
- One natural sub-module, `div_step`: combinational restoring step with inputs rem, dvd and divisor and outputs next rem, next dvd and quotient bit. It uses the existing subtractor for the trial subtract.

## Test plan
- Unsigned 100 / 7 → `done` exactly 34 cycles after accept; quotient 14, remainder 2, `div_by_zero`=0.
- Signed −7 / 2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- 5 / 0, signed and unsigned → quotient 0xFFFFFFFF, remainder 5, `div_by_zero`=1, latency still 34.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- `start` pulsed with new operands at cycle 10 of a busy run → ignored; the original result is unchanged and there is exactly one `done`.
- `rst_n` low at cycle 20 of a run → all outputs 0 immediately and no `done`; a new start after release gives correct 34-cycle results.
